// File: rtl/spawn_gen.sv
// spawn_gen: packs serial LFSR bits into lane/type/gap spawn requests,
// counts the gap down in game ticks, then offers the request via valid/ready.
module spawn_gen #(
  parameter int LANE_BITS = 3,
  parameter int LANES     = 6,
  parameter int TYPE_BITS = 2,
  parameter int GAP_BITS  = 3,
  parameter int MIN_GAP   = 2
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic                 enable,
  input  logic                 rnd_bit,
  input  logic                 rnd_en,
  input  logic                 tick,
  output logic                 spawn_valid,
  input  logic                 spawn_ready,
  output logic [LANE_BITS-1:0] spawn_lane,
  output logic [TYPE_BITS-1:0] spawn_type,
  output logic [7:0]           spawn_count,
  output logic [7:0]           reject_count
);

  localparam int TOTAL    = LANE_BITS + TYPE_BITS + GAP_BITS;
  localparam int CNT_BITS = $clog2(TOTAL);
  localparam int GC_BITS  = $clog2(MIN_GAP + (1 << GAP_BITS));

  localparam logic [CNT_BITS-1:0]  LAST_BIT = CNT_BITS'(TOTAL - 1);
  localparam logic [LANE_BITS:0]   LANE_LIM = (LANE_BITS + 1)'(LANES);
  localparam logic [GC_BITS-1:0]   GAP_BASE = GC_BITS'(MIN_GAP);
  localparam logic [GC_BITS-1:0]   GAP_ONE  = GC_BITS'(1);
  localparam logic [CNT_BITS-1:0]  BIT_ONE  = CNT_BITS'(1);

  typedef enum logic [1:0] {
    COLLECT,
    WAIT,
    OFFER
  } state_t;

  state_t               state_q, state_d;
  logic [TOTAL-2:0]     word_q, word_d;
  logic [CNT_BITS-1:0]  bit_q, bit_d;
  logic [GC_BITS-1:0]   gap_q, gap_d;
  logic [LANE_BITS-1:0] lane_q, lane_d;
  logic [TYPE_BITS-1:0] type_q, type_d;
  logic                 valid_q, valid_d;
  logic [7:0]           scount_q, scount_d;
  logic [7:0]           rcount_q, rcount_d;

  // Only TOTAL-1 bits are stored: the final bit is decoded straight
  // from rnd_bit on the capturing edge, so the full word never needs a flop.
  logic [TOTAL-1:0]     word_full;
  logic [LANE_BITS-1:0] f_lane;
  logic [TYPE_BITS-1:0] f_type;
  logic [GAP_BITS-1:0]  f_gap;

  assign word_full = {word_q, rnd_bit};
  assign f_lane    = word_full[TOTAL-1 -: LANE_BITS];
  assign f_type    = word_full[GAP_BITS +: TYPE_BITS];
  assign f_gap     = word_full[GAP_BITS-1:0];

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    lane_d   = lane_q;
    type_d   = type_q;
    valid_d  = valid_q;
    scount_d = scount_q;
    rcount_d = rcount_q;
    if (!enable) begin
      state_d = COLLECT;
      bit_d   = '0;
      gap_d   = '0;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (rnd_en) begin
            word_d = word_full[TOTAL-2:0];
            if (bit_q == LAST_BIT) begin
              bit_d = '0;
              if ({1'b0, f_lane} < LANE_LIM) begin
                lane_d  = f_lane;
                type_d  = f_type;
                gap_d   = GAP_BASE + GC_BITS'(f_gap);
                state_d = WAIT;
              end else begin
                rcount_d = rcount_q + 8'd1;
              end
            end else begin
              bit_d = bit_q + BIT_ONE;
            end
          end
        end
        WAIT: begin
          if (tick) begin
            gap_d = gap_q - GAP_ONE;
            if (gap_q == GAP_ONE) begin
              state_d = OFFER;
              valid_d = 1'b1;
            end
          end
        end
        OFFER: begin
          if (spawn_ready) begin
            scount_d = scount_q + 8'd1;
            state_d  = COLLECT;
            bit_d    = '0;
            valid_d  = 1'b0;
          end
        end
        default: begin
          state_d = COLLECT;
          bit_d   = '0;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= COLLECT;
      word_q   <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
      lane_q   <= '0;
      type_q   <= '0;
      valid_q  <= 1'b0;
      scount_q <= 8'd0;
      rcount_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      lane_q   <= lane_d;
      type_q   <= type_d;
      valid_q  <= valid_d;
      scount_q <= scount_d;
      rcount_q <= rcount_d;
    end
  end

  assign spawn_valid  = valid_q;
  assign spawn_lane   = lane_q;
  assign spawn_type   = type_q;
  assign spawn_count  = scount_q;
  assign reject_count = rcount_q;

endmodule

// File: tb/tb_spawn_gen.sv
// tb_spawn_gen: scenario tasks plus a randomized run, checked against
// expectations derived arithmetically from each 8-bit request word.
module tb_spawn_gen;

  localparam int NL = 6;
  localparam int MG = 2;

  logic clk = 1'b0;
  logic clr_n = 1'b0;
  logic enable = 1'b0;
  logic rnd_bit = 1'b0;
  logic rnd_en = 1'b0;
  logic tick = 1'b0;
  logic spawn_ready = 1'b0;
  logic spawn_valid;
  logic [2:0] spawn_lane;
  logic [1:0] spawn_type;
  logic [7:0] spawn_count;
  logic [7:0] reject_count;

  int tests_run = 0;
  int failed = 0;
  int m_spawn = 0;
  int m_reject = 0;

  always #5 clk = ~clk;

  spawn_gen dut (
    .clk(clk),
    .clr_n(clr_n),
    .enable(enable),
    .rnd_bit(rnd_bit),
    .rnd_en(rnd_en),
    .tick(tick),
    .spawn_valid(spawn_valid),
    .spawn_ready(spawn_ready),
    .spawn_lane(spawn_lane),
    .spawn_type(spawn_type),
    .spawn_count(spawn_count),
    .reject_count(reject_count)
  );

  function automatic int w_lane(input logic [7:0] w);
    return int'(w) / 32;
  endfunction

  function automatic int w_type(input logic [7:0] w);
    return (int'(w) / 8) % 4;
  endfunction

  function automatic int w_ticks(input logic [7:0] w);
    return MG + int'(w) % 8;
  endfunction

  // Feed the top n bits of w, MSB first; optional idle holes between bits.
  task automatic feed_bits(input logic [7:0] w, input int n, input bit gappy);
    for (int i = 7; i > 7 - n; i--) begin
      if (gappy) begin
        repeat ($urandom_range(0, 2)) begin
          rnd_en = 1'b0;
          rnd_bit = 1'($urandom);
          @(negedge clk);
        end
      end
      rnd_bit = w[i];
      rnd_en = 1'b1;
      @(negedge clk);
    end
    rnd_en = 1'b0;
    rnd_bit = 1'b0;
  endtask

  // Pulse ticks until valid appears; n = tick count, -1 if limit expires.
  task automatic tick_until_valid(input int limit, input int space, output int n);
    n = -1;
    if (spawn_valid) n = 0;
    for (int i = 1; i <= limit && n < 0; i++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      if (spawn_valid) n = i;
      else repeat (space) @(negedge clk);
    end
  endtask

  task automatic accept();
    spawn_ready = 1'b1;
    @(negedge clk);
    spawn_ready = 1'b0;
    m_spawn++;
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({spawn_valid, spawn_lane, spawn_type} !== 6'd0) begin
      failed++;
      $display("FAIL reset_outputs got %b want 0", {spawn_valid, spawn_lane, spawn_type});
    end
    tests_run++;
    if (spawn_count !== 8'd0 || reject_count !== 8'd0) begin
      failed++;
      $display("FAIL reset_counts got %0d/%0d want 0/0", spawn_count, reject_count);
    end
    clr_n = 1'b1;
    enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int n;
    feed_bits(8'b10110011, 8, 1'b0);
    tick_until_valid(20, 3, n);
    tests_run++;
    if (n !== 5) begin
      failed++;
      $display("FAIL basic_ticks got %0d want 5", n);
    end
    tests_run++;
    if (spawn_lane !== 3'd5 || spawn_type !== 2'd2) begin
      failed++;
      $display("FAIL basic_fields got %0d/%0d want 5/2", spawn_lane, spawn_type);
    end
    accept();
    tests_run++;
    if (spawn_valid !== 1'b0 || spawn_count !== 8'd1) begin
      failed++;
      $display("FAIL basic_accept got v=%b c=%0d want v=0 c=1", spawn_valid, spawn_count);
    end
  endtask

  task automatic test_reject();
    int n;
    feed_bits(8'b11100000, 8, 1'b0);
    m_reject++;
    tests_run++;
    if (reject_count !== 8'(m_reject) || spawn_valid !== 1'b0) begin
      failed++;
      $display("FAIL reject_count got %0d v=%b want %0d v=0", reject_count, spawn_valid, m_reject);
    end
    feed_bits(8'b00101000, 8, 1'b0);
    tick_until_valid(20, 1, n);
    tests_run++;
    if (n !== 2 || spawn_lane !== 3'd1 || spawn_type !== 2'd1) begin
      failed++;
      $display("FAIL reject_next got n=%0d l=%0d t=%0d want 2/1/1", n, spawn_lane, spawn_type);
    end
    accept();
  endtask

  task automatic test_backpressure();
    int n;
    logic [7:0] w;
    w = 8'($urandom_range(0, 191));
    feed_bits(w, 8, 1'b0);
    tick_until_valid(20, 0, n);
    tests_run++;
    if (n !== w_ticks(w)) begin
      failed++;
      $display("FAIL bp_ticks got %0d want %0d", n, w_ticks(w));
    end
    for (int c = 0; c < 10; c++) begin
      rnd_en = 1'($urandom);
      rnd_bit = 1'($urandom);
      tick = 1'($urandom);
      @(negedge clk);
      tests_run++;
      if (spawn_valid !== 1'b1 || int'(spawn_lane) != w_lane(w) || int'(spawn_type) != w_type(w)) begin
        failed++;
        $display("FAIL bp_hold c=%0d got v=%b l=%0d t=%0d want 1/%0d/%0d",
                 c, spawn_valid, spawn_lane, spawn_type, w_lane(w), w_type(w));
      end
    end
    rnd_en = 1'b0;
    tick = 1'b0;
    accept();
    @(negedge clk);
    tests_run++;
    if (spawn_count !== 8'(m_spawn) || spawn_valid !== 1'b0) begin
      failed++;
      $display("FAIL bp_accept got c=%0d v=%b want %0d/0", spawn_count, spawn_valid, m_spawn);
    end
  endtask

  task automatic test_abort();
    int n;
    feed_bits(8'b01010111, 8, 1'b0);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    tests_run++;
    if (spawn_valid !== 1'b0 || spawn_count !== 8'(m_spawn)) begin
      failed++;
      $display("FAIL abort_wait got v=%b c=%0d want 0/%0d", spawn_valid, spawn_count, m_spawn);
    end
    feed_bits(8'b10001001, 8, 1'b0);
    tick_until_valid(20, 0, n);
    tests_run++;
    if (n !== 3 || spawn_lane !== 3'd4 || spawn_type !== 2'd1) begin
      failed++;
      $display("FAIL abort_wait_next got n=%0d l=%0d want 3/4", n, spawn_lane);
    end
    enable = 1'b0;
    spawn_ready = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    spawn_ready = 1'b0;
    tests_run++;
    if (spawn_valid !== 1'b0 || spawn_count !== 8'(m_spawn)) begin
      failed++;
      $display("FAIL abort_offer got v=%b c=%0d want 0/%0d", spawn_valid, spawn_count, m_spawn);
    end
    feed_bits(8'b11100000, 3, 1'b0);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    feed_bits(8'b01101010, 8, 1'b0);
    tick_until_valid(20, 0, n);
    tests_run++;
    if (n !== 4 || spawn_lane !== 3'd3 || spawn_type !== 2'd1) begin
      failed++;
      $display("FAIL abort_partial got n=%0d l=%0d t=%0d want 4/3/1", n, spawn_lane, spawn_type);
    end
    accept();
  endtask

  task automatic test_clear_midwait();
    int n;
    bit seen;
    feed_bits(8'b01101000, 8, 1'b0);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    #2 clr_n = 1'b0;
    #1;
    tests_run++;
    if ({spawn_valid, spawn_lane, spawn_type, spawn_count, reject_count} !== 22'd0) begin
      failed++;
      $display("FAIL clr_async got l=%0d t=%0d c=%0d r=%0d want 0",
               spawn_lane, spawn_type, spawn_count, reject_count);
    end
    @(negedge clk);
    clr_n = 1'b1;
    m_spawn = 0;
    m_reject = 0;
    feed_bits(8'b01000000, 7, 1'b0);
    seen = 1'b0;
    tick = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (spawn_valid) seen = 1'b1;
    end
    tick = 1'b0;
    tests_run++;
    if (seen !== 1'b0) begin
      failed++;
      $display("FAIL clr_seven_bits got valid=1 want 0");
    end
    feed_bits(8'h00, 1, 1'b0);
    tick_until_valid(20, 0, n);
    tests_run++;
    if (n !== 2 || spawn_lane !== 3'd2) begin
      failed++;
      $display("FAIL clr_eighth_bit got n=%0d l=%0d want 2/2", n, spawn_lane);
    end
    accept();
  endtask

  task automatic test_random_wrap();
    int n;
    logic [7:0] w;
    while (m_spawn < 260) begin
      w = 8'($urandom);
      if ($urandom_range(0, 3) == 0) w[2:0] = 3'd0;
      feed_bits(w, 8, 1'b1);
      if (w_lane(w) >= NL) begin
        m_reject++;
        tests_run++;
        if (reject_count !== 8'(m_reject) || spawn_valid !== 1'b0) begin
          failed++;
          $display("FAIL rnd_reject w=%h got %0d want %0d", w, reject_count, m_reject);
        end
      end else begin
        tick_until_valid(20, $urandom_range(0, 2), n);
        tests_run++;
        if (n !== w_ticks(w) || int'(spawn_lane) != w_lane(w) || int'(spawn_type) != w_type(w)) begin
          failed++;
          $display("FAIL rnd_req w=%h got n=%0d l=%0d t=%0d want %0d/%0d/%0d",
                   w, n, spawn_lane, spawn_type, w_ticks(w), w_lane(w), w_type(w));
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        accept();
        tests_run++;
        if (spawn_count !== 8'(m_spawn) || spawn_valid !== 1'b0) begin
          failed++;
          $display("FAIL rnd_accept got c=%0d v=%b want %0d/0", spawn_count, spawn_valid, m_spawn % 256);
        end
        if (m_spawn == 256) begin
          tests_run++;
          if (spawn_count !== 8'd0) begin
            failed++;
            $display("FAIL wrap got %0d want 0", spawn_count);
          end
        end
      end
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog expired tests=%0d failed=%0d", tests_run, failed);
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_reject();
    test_backpressure();
    test_abort();
    test_clear_midwait();
    test_random_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
